// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU and the multiply/divide unit.
// Holds the ALUOp and md_op codes, the MD state type and an op classifier.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SRL  = 4'd4;
    localparam logic [3:0] ALU_SRA  = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    // Multi-cycle ops occupy the unit; moves and no-ops complete at acceptance.
    function automatic logic md_is_long(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit with HI/LO registers.
// Results are computed from latched operands and committed only on the final busy cycle.
module md_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       md_op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_t        state, state_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_load;
    logic             accept_md;
    logic             finish;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;

    logic signed [2*WIDTH-1:0] sprod;
    logic        [2*WIDTH-1:0] uprod;
    logic signed [WIDTH-1:0]   sa, sdiv, sq, sr;
    logic        [WIDTH-1:0]   udiv, uq, ur;
    logic                      div_zero, div_ovf;
    logic        [WIDTH-1:0]   res_hi, res_lo;

    assign busy     = (state == MD_RUN);
    assign cnt_load = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? CW'(MUL_CYCLES - 1)
                                                                  : CW'(DIV_CYCLES - 1);

    always_comb begin
        state_next = state;
        accept_md  = 1'b0;
        finish     = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start && md_is_long(md_op)) begin
                    accept_md  = 1'b1;
                    state_next = MD_RUN;
                end
            end
            MD_RUN: begin
                if (cnt == '0) begin
                    finish     = 1'b1;
                    state_next = MD_IDLE;
                end
            end
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            done  <= finish;
            if (accept_md)
                cnt <= cnt_load;
            else if (busy && (cnt != '0))
                cnt <= cnt - 1'b1;
            if (finish) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if ((state == MD_IDLE) && start && (md_op == MD_MTHI)) begin
                hi <= a;
            end else if ((state == MD_IDLE) && start && (md_op == MD_MTLO)) begin
                lo <= a;
            end
        end
    end

    // Operand latch: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept_md) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= md_op;
        end
    end

    // Divisor is forced to 1 in the special cases so the operators never see them.
    always_comb begin
        sa       = $signed(a_q);
        div_zero = (b_q == '0);
        div_ovf  = (a_q == MOST_NEG) && (b_q == '1);
        udiv     = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;
        sdiv     = $signed(udiv);
        sq       = sa / sdiv;
        sr       = sa % sdiv;
        uq       = a_q / udiv;
        ur       = a_q % udiv;
        sprod    = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
        uprod    = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        res_hi   = '0;
        res_lo   = '0;
        case (op_q)
            MD_MULT: begin
                res_hi = sprod[2*WIDTH-1:WIDTH];
                res_lo = sprod[WIDTH-1:0];
            end
            MD_MULTU: begin
                res_hi = uprod[2*WIDTH-1:WIDTH];
                res_lo = uprod[WIDTH-1:0];
            end
            MD_DIV: begin
                if (div_zero) begin
                    res_hi = a_q;
                    res_lo = '1;
                end else if (div_ovf) begin
                    res_hi = '0;
                    res_lo = MOST_NEG;
                end else begin
                    res_hi = sr;
                    res_lo = sq;
                end
            end
            MD_DIVU: begin
                if (div_zero) begin
                    res_hi = a_q;
                    res_lo = '1;
                end else begin
                    res_hi = ur;
                    res_lo = uq;
                end
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU: zero-latency combinational result plus the sequential MD unit.
// busy from the MD unit drives the hazard unit; the ALU path ignores reset and busy.
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] C,
    input  logic [2:0]       md_op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;

    assign shamt = B[SHW-1:0];

    always_comb begin
        C = '0;
        case (ALUOp)
            ALU_ADD:  C = A + B;
            ALU_SUB:  C = A - B;
            ALU_AND:  C = A & B;
            ALU_OR:   C = A | B;
            ALU_SRL:  C = A >> shamt;
            ALU_SRA:  C = $signed(A) >>> shamt;
            ALU_XOR:  C = A ^ B;
            ALU_NOR:  C = ~(A | B);
            ALU_SLL:  C = A << shamt;
            ALU_SLT:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: C = {{(WIDTH-1){1'b0}}, (A < B)};
            default:  C = '0;
        endcase
    end

    md_unit #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md (
        .clk   (clk),
        .reset (reset),
        .a     (A),
        .b     (B),
        .md_op (md_op),
        .start (start),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

endmodule
